// File: rtl/down_counter_pkg.sv
// ---------------------------------------------------------------------------
// down_counter_pkg
// Shared types and defaults for the down_counter_sync block.
//   dc_state_e : FSM state encoding (RUN counts, HALT parks at zero)
//   DC_WIDTH   : default counter width
// ---------------------------------------------------------------------------
package down_counter_pkg;

  localparam int DC_WIDTH = 3;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } dc_state_e;

endpackage : down_counter_pkg

// File: rtl/dn_tff_cell.sv
// ---------------------------------------------------------------------------
// dn_tff_cell
// One bit of the down counter: a toggle flop with synchronous active-high
// reset and a synchronous parallel load.  Priority: reset > load > toggle.
// Ports:
//   i_clk     : rising-edge clock
//   i_rst     : synchronous active-high reset
//   i_rst_val : value taken on reset
//   i_ld      : parallel load strobe
//   i_d       : value taken on load
//   i_t       : toggle enable
//   o_q       : stored bit
// ---------------------------------------------------------------------------
module dn_tff_cell (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rst_val,
  input  logic i_ld,
  input  logic i_d,
  input  logic i_t,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= i_rst_val;
    end else if (i_ld) begin
      r_q <= i_d;
    end else if (i_t) begin
      r_q <= ~r_q;
    end
  end

  assign o_q = r_q;

endmodule : dn_tff_cell

// File: rtl/down_counter_sync.sv
// ---------------------------------------------------------------------------
// down_counter_sync
// Synchronous binary down counter built from per-bit toggle cells, with
// parallel load, count enable, and auto-reload or one-shot operation.
// Used as a timer/prescaler: tc flags zero, borrow pulses on each underflow.
//
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   en        : count enable (decrement once per clk while RUN)
//   load      : parallel load strobe (also sets the reload value)
//   load_val  : value captured on load
//   oneshot   : 1 = park at zero in HALT on underflow, 0 = reload and continue
//   q         : current count
//   q_not     : bitwise ~q
//   tc        : q == 0 (combinational from q only)
//   borrow    : registered one-cycle pulse after each underflow edge
//   busy      : FSM is in RUN
//   state_dbg : current FSM state, for observation only
//
// Control interface: there is no valid/ready handshake. load and en are
// level-sampled strobes acted on at every rising edge with priority
// rst > load > en; every effect appears on q/borrow one edge later.
// ---------------------------------------------------------------------------
module down_counter_sync
  import down_counter_pkg::*;
#(
  parameter int               WIDTH     = DC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_not,
  output logic             tc,
  output logic             borrow,
  output logic             busy,
  output dc_state_e        state_dbg
);

  dc_state_e        r_state;
  dc_state_e        w_state_nxt;
  logic [WIDTH-1:0] r_reload;
  logic             r_borrow;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH:0]   w_low_zero;   // w_low_zero[i] = (q[i-1:0] == 0)
  logic             w_run;
  logic             w_tc;
  logic             w_count;      // ordinary decrement this edge
  logic             w_underflow;  // count request while q == 0
  logic             w_cell_ld;
  logic [WIDTH-1:0] w_cell_d;
  logic [WIDTH-1:0] w_t;

  // Borrow chain: a bit toggles on decrement exactly when every lower bit
  // is zero. The top of the chain doubles as the zero detect.
  always_comb begin
    w_low_zero[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_low_zero[i+1] = w_low_zero[i] & ~w_q[i];
    end
  end

  assign w_tc        = w_low_zero[WIDTH];
  assign w_run       = (r_state == RUN);
  assign w_count     = w_run & ~load & en & ~w_tc;
  assign w_underflow = w_run & ~load & en &  w_tc;

  // The cells' parallel-load path serves both an explicit load and the
  // auto-reload on underflow. In one-shot mode the underflow loads nothing
  // and toggles nothing, so q simply stays at zero.
  assign w_cell_ld = load | (w_underflow & ~oneshot);
  assign w_cell_d  = load ? load_val : r_reload;
  assign w_t       = {WIDTH{w_count}} & w_low_zero[WIDTH-1:0];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    dn_tff_cell u_cell (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_rst_val (RESET_VAL[gi]),
      .i_ld      (w_cell_ld),
      .i_d       (w_cell_d[gi]),
      .i_t       (w_t[gi]),
      .o_q       (w_q[gi])
    );
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: load always returns to RUN; a one-shot underflow parks.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN: begin
        if (w_underflow && oneshot) begin
          w_state_nxt = HALT;
        end
      end
      HALT: begin
        if (load) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Reload register follows every explicit load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reload <= RESET_VAL;
    end else if (load) begin
      r_reload <= load_val;
    end
  end

  // Borrow is registered so it carries no combinational input path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_borrow <= 1'b0;
    end else begin
      r_borrow <= w_underflow;
    end
  end

  assign q         = w_q;
  assign q_not     = ~w_q;
  assign tc        = w_tc;
  assign borrow    = r_borrow;
  assign busy      = w_run;
  assign state_dbg = r_state;

endmodule : down_counter_sync

// File: tb/tb_down_counter_sync.sv
module tb_down_counter_sync;
  import down_counter_pkg::*;

  localparam int W  = 3;
  localparam int RV = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         oneshot = 1'b0;
  logic [W-1:0] q, q_not;
  logic         tc, borrow, busy;
  dc_state_e    state_dbg;

  down_counter_sync #(.WIDTH(W), .RESET_VAL(3'd7)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .load_val  (load_val),
    .oneshot   (oneshot),
    .q         (q),
    .q_not     (q_not),
    .tc        (tc),
    .borrow    (borrow),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Abstract view: an integer count, a reload integer, a halted flag and
  // the borrow pulse, updated from the rules at each rising edge.
  int   m_q = 0;
  int   m_reload = 0;
  bit   m_halt = 0;
  bit   m_borrow = 0;
  bit   model_valid = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q = RV; m_reload = RV; m_halt = 0; m_borrow = 0;
      model_valid = 1;
    end else if (load) begin
      m_q = int'(load_val); m_reload = int'(load_val); m_halt = 0; m_borrow = 0;
    end else if (m_halt || !en) begin
      m_borrow = 0;
    end else if (m_q == 0) begin
      m_borrow = 1;
      if (oneshot) m_halt = 1;
      else m_q = m_reload;
    end else begin
      m_q = (m_q - 1) % (1 << W);
      m_borrow = 0;
    end
  end

  // ---------------- compare process (every cycle once reset seen) ----------------
  always @(negedge clk) begin
    if (model_valid) begin
      chk("no_x", {28'd0, $isunknown({q, q_not, tc, borrow, busy, state_dbg})}, 32'd0);
      chk("q", {29'd0, q}, m_q);
      chk("q_not", {29'd0, q_not}, (~m_q) & 7);
      chk("tc", {31'd0, tc}, (m_q == 0));
      chk("borrow", {31'd0, borrow}, {31'd0, m_borrow});
      chk("busy", {31'd0, busy}, {31'd0, !m_halt});
      chk("state", {31'd0, state_dbg}, m_halt ? {31'd0, HALT} : {31'd0, RUN});
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; applies inputs across one rising edge and
  // returns at the next falling edge with outputs settled.
  task automatic cyc(input bit r, input bit l, input int lv, input bit e, input bit os);
    rst = r; load = l; load_val = W'(lv); en = e; oneshot = os;
    @(negedge clk);
  endtask

  int exp1 [9] = '{6, 5, 4, 3, 2, 1, 0, 7, 6};
  int exp2 [6] = '{2, 1, 0, 0, 0, 0};
  int exp3 [6] = '{4, 3, 2, 1, 0, 5};
  int en5  [4] = '{1, 0, 1, 0};
  int exp5 [4] = '{3, 3, 2, 2};

  initial begin
    @(negedge clk);
    // 1: reset then free-running auto-reload
    cyc(1, 0, 0, 0, 0);
    chk("t1_reset_q", {29'd0, q}, 7);
    chk("t1_reset_borrow", {31'd0, borrow}, 0);
    chk("t1_reset_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("t1_q", {29'd0, q}, exp1[i]);
      chk("t1_borrow", {31'd0, borrow}, (i == 7));
      chk("t1_tc", {31'd0, tc}, (i == 6));
    end
    // 2: one-shot from 3
    cyc(0, 1, 3, 0, 1);
    chk("t2_load_q", {29'd0, q}, 3);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 1);
      chk("t2_q", {29'd0, q}, exp2[i]);
      chk("t2_borrow", {31'd0, borrow}, (i == 3));
      chk("t2_busy", {31'd0, busy}, (i < 3));
    end
    // 3: load from HALT, count down and wrap to new reload value
    cyc(0, 1, 5, 0, 0);
    chk("t3_q", {29'd0, q}, 5);
    chk("t3_busy", {31'd0, busy}, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("t3_cnt", {29'd0, q}, exp3[i]);
      chk("t3_borrow", {31'd0, borrow}, (i == 5));
    end
    // 4: load beats en; rst beats load and restores reload of 7
    cyc(0, 1, 2, 1, 0);
    chk("t4_q", {29'd0, q}, 2);
    chk("t4_borrow", {31'd0, borrow}, 0);
    cyc(1, 1, 4, 1, 0);
    chk("t4_rst_q", {29'd0, q}, 7);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);
    chk("t4_wrap_q", {29'd0, q}, 7);
    chk("t4_wrap_borrow", {31'd0, borrow}, 1);
    // 5: gated enable from 4
    cyc(0, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, en5[i][0], 0);
      chk("t5_q", {29'd0, q}, exp5[i]);
      chk("t5_q_not", {29'd0, q_not}, (~exp5[i]) & 7);
      chk("t5_borrow", {31'd0, borrow}, 0);
    end
    // 6: reload value of zero underflows every enabled edge
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("t6_q", {29'd0, q}, 0);
      chk("t6_borrow", {31'd0, borrow}, 1);
    end
    // 7: randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) < 2,
          $urandom_range(0, 99) < 10,
          int'($urandom_range(0, 7)),
          $urandom_range(0, 99) < 75,
          $urandom_range(0, 1) == 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_down_counter_sync
